ide_autoconfig: RTL

//  Zorro II AutoConfig responder for the IDE board function; sits directly upstream of the IDE

---
 rtl/ide_autoconfig.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ide_autoconfig.sv
// ============================================================================
// Module   : ide_autoconfig
// Function : Zorro II AutoConfig responder (64K IDE board) and window decoder.
//            Optional macro AUTOBOOT_EN enables the diag ROM vector nibbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ide_autoconfig #(
    parameter logic [15:0] MANUF_ID   = 16'h144A,
    parameter logic [7:0]  PRODUCT_ID = 8'h05,
    parameter logic [31:0] SERIAL     = 32'h0,
    parameter logic [15:0] ROM_OFFSET = 16'h4000
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic [23:1] ADDR,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        RW,
    input  logic [3:0]  DIN,
    output logic [3:0]  DOUT,
    output logic        DOE,
    input  logic        CFGIN_n,
    output logic        CFGOUT_n,
    output logic        configured,
    output logic        ide_access
);

`ifdef AUTOBOOT_EN
    localparam logic [7:0] c_er_type = 8'hD1;
`else
    localparam logic [7:0] c_er_type = 8'hC1;
    logic w_unused_rom;
    assign w_unused_rom = ^ROM_OFFSET;
`endif

    typedef enum logic [1:0] {
        ST_UNCONFIG   = 2'd0,
        ST_CONFIGURED = 2'd1,
        ST_SHUTUP     = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_base, w_base_nxt;
    logic [3:0]  r_hi_nib, w_hi_nib_nxt;
    logic        r_wr_done, w_wr_done_nxt;
    logic        r_cfgout_n, w_cfgout_n_nxt;
    logic        r_configured, w_configured_nxt;

    logic        w_cfg_sel;
    logic        w_wr_take;
    logic [3:0]  w_nib;
    logic        w_unused_addr;

    assign w_unused_addr = ^ADDR[15:8];

    assign w_cfg_sel = (r_state == ST_UNCONFIG) && !CFGIN_n && !AS_n
                       && (ADDR[23:16] == 8'hE8);
    assign w_wr_take = w_cfg_sel && !RW && !UDS_n && !r_wr_done;

    // ADDR[7:1] is the word index: byte offset $xx maps to index $xx/2.
    always_comb begin
        w_nib = 4'hF;
        case (ADDR[7:1])
            7'h00: w_nib = c_er_type[7:4];
            7'h01: w_nib = c_er_type[3:0];
            7'h02: w_nib = ~PRODUCT_ID[7:4];
            7'h03: w_nib = ~PRODUCT_ID[3:0];
            7'h08: w_nib = ~MANUF_ID[15:12];
            7'h09: w_nib = ~MANUF_ID[11:8];
            7'h0A: w_nib = ~MANUF_ID[7:4];
            7'h0B: w_nib = ~MANUF_ID[3:0];
            7'h0C: w_nib = ~SERIAL[31:28];
            7'h0D: w_nib = ~SERIAL[27:24];
            7'h0E: w_nib = ~SERIAL[23:20];
            7'h0F: w_nib = ~SERIAL[19:16];
            7'h10: w_nib = ~SERIAL[15:12];
            7'h11: w_nib = ~SERIAL[11:8];
            7'h12: w_nib = ~SERIAL[7:4];
            7'h13: w_nib = ~SERIAL[3:0];
`ifdef AUTOBOOT_EN
            7'h14: w_nib = ~ROM_OFFSET[15:12];
            7'h15: w_nib = ~ROM_OFFSET[11:8];
            7'h16: w_nib = ~ROM_OFFSET[7:4];
            7'h17: w_nib = ~ROM_OFFSET[3:0];
`endif
            default: w_nib = 4'hF;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_hi_nib_nxt     = r_hi_nib;
        w_wr_done_nxt    = r_wr_done;
        w_cfgout_n_nxt   = r_cfgout_n;
        w_configured_nxt = r_configured;
        if (AS_n) begin
            w_wr_done_nxt = 1'b0;
            // Chain is only released between bus cycles, never mid-cycle.
            if (r_state != ST_UNCONFIG) begin
                w_cfgout_n_nxt = 1'b0;
            end
        end
        if (w_wr_take) begin
            w_wr_done_nxt = 1'b1;
            case (ADDR[7:1])
                7'h25: w_hi_nib_nxt = DIN;
                7'h24: begin
                    w_base_nxt       = {DIN, r_hi_nib};
                    w_state_nxt      = ST_CONFIGURED;
                    w_configured_nxt = 1'b1;
                end
                7'h26: w_state_nxt = ST_SHUTUP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state      <= ST_UNCONFIG;
            r_base       <= 8'h00;
            r_hi_nib     <= 4'h0;
            r_wr_done    <= 1'b0;
            r_cfgout_n   <= 1'b1;
            r_configured <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_base       <= w_base_nxt;
            r_hi_nib     <= w_hi_nib_nxt;
            r_wr_done    <= w_wr_done_nxt;
            r_cfgout_n   <= w_cfgout_n_nxt;
            r_configured <= w_configured_nxt;
        end
    end

    assign DOE        = w_cfg_sel && RW;
    assign DOUT       = w_nib;
    assign CFGOUT_n   = r_cfgout_n;
    assign configured = r_configured;
    assign ide_access = r_configured && !AS_n && (ADDR[23:16] == r_base);

endmodule

`default_nettype wire
